// File: rtl/tref_sched_pkg.sv
// Shared definitions for the Tref leak scheduler: operation encoding and FSM states.
package tref_sched_pkg;

  localparam logic OP_LEAK  = 1'b1;
  localparam logic OP_SPIKE = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/tref_leak_scheduler_if.sv
// Spike request channel and core operation channel of the Tref leak scheduler.
interface tref_leak_scheduler_if #(
  parameter int ADDR_W = 8
);

  // Both channels: a transfer happens on a rising edge where VALID && READY;
  // once VALID is high the payload holds steady until that transfer occurs.
  logic              SPIKE_VALID;
  logic [ADDR_W-1:0] SPIKE_ADDR;
  logic              SPIKE_READY;

  logic              CORE_VALID;
  logic              CORE_LEAK;
  logic [ADDR_W-1:0] CORE_ADDR;
  logic              CORE_READY;

  // Environment side: spike source and neuron-update core.
  modport master (
    output SPIKE_VALID, SPIKE_ADDR, CORE_READY,
    input  SPIKE_READY, CORE_VALID, CORE_LEAK, CORE_ADDR
  );

  // Scheduler side.
  modport slave (
    input  SPIKE_VALID, SPIKE_ADDR, CORE_READY,
    output SPIKE_READY, CORE_VALID, CORE_LEAK, CORE_ADDR
  );

endinterface

// File: rtl/tref_timer.sv
// Time-reference timer: free-running modulo counter gated by ENABLE, one-cycle tick per period.
module tref_timer #(
  parameter int TREF_PERIOD = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic ENABLE,
  output logic TREF_TICK
);

  localparam int CNT_W = (TREF_PERIOD > 1) ? $clog2(TREF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TREF_PERIOD - 1);

  logic [CNT_W-1:0] count;

  // Disabling the timer restarts the period from zero rather than pausing it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (!ENABLE || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign TREF_TICK = ENABLE && (count == LAST);

endmodule

// File: rtl/tref_leak_scheduler.sv
// Shares the neuron-update core between AER spikes and periodic leak sweeps
// using round-robin arbitration into a single-entry output register.
module tref_leak_scheduler
  import tref_sched_pkg::*;
#(
  parameter int TREF_PERIOD = 50000,
  parameter int N_NEURONS   = 256,
  parameter int ADDR_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  tref_leak_scheduler_if.slave  bus,
  output logic                  TREF_TICK,
  output logic                  BUSY,
  output logic                  OVERRUN,
  output state_t                STATE
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEURONS - 1);

  state_t            state;
  state_t            state_next;
  logic              pending;
  logic              last_grant;
  logic [ADDR_W-1:0] leak_addr;
  logic              leak_cand;
  logic              start_sweep;
  logic              load_en;
  logic              contested;
  logic              grant_spike;
  logic              grant_leak;

  tref_timer #(
    .TREF_PERIOD(TREF_PERIOD)
  ) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .ENABLE    (ENABLE),
    .TREF_TICK (TREF_TICK)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending) state_next = SWEEP;
      SWEEP:   if (grant_leak && (leak_addr == LAST_ADDR)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    leak_cand   = (state == SWEEP);
    start_sweep = (state == IDLE) && pending;
    BUSY        = (state == SWEEP) || pending;
  end

  assign STATE = state;

  // Round robin only matters when both sources compete; a lone requester always wins.
  assign load_en         = !bus.CORE_VALID || bus.CORE_READY;
  assign contested       = bus.SPIKE_VALID && leak_cand;
  assign grant_spike     = load_en && bus.SPIKE_VALID && (!leak_cand || !last_grant);
  assign grant_leak      = load_en && leak_cand && (!bus.SPIKE_VALID || last_grant);
  assign bus.SPIKE_READY = grant_spike;

  // Only one tick is remembered; a second one before the sweep starts is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending    <= 1'b0;
      OVERRUN    <= 1'b0;
      leak_addr  <= '0;
      last_grant <= 1'b0;
    end else begin
      if (TREF_TICK && pending) OVERRUN <= 1'b1;

      if (start_sweep)    pending <= 1'b0;
      else if (TREF_TICK) pending <= 1'b1;

      if (start_sweep)     leak_addr <= '0;
      else if (grant_leak) leak_addr <= leak_addr + ADDR_W'(1);

      if (load_en && contested) last_grant <= grant_spike;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.CORE_VALID <= 1'b0;
      bus.CORE_LEAK  <= 1'b0;
      bus.CORE_ADDR  <= '0;
    end else if (load_en) begin
      bus.CORE_VALID <= grant_spike || grant_leak;
      if (grant_leak) begin
        bus.CORE_LEAK <= OP_LEAK;
        bus.CORE_ADDR <= leak_addr;
      end else if (grant_spike) begin
        bus.CORE_LEAK <= OP_SPIKE;
        bus.CORE_ADDR <= bus.SPIKE_ADDR;
      end
    end
  end

endmodule

// File: doc/tref_leak_scheduler.md
# tref_leak_scheduler

Sequencer that sits in front of the neuron-update core and shares it between two request sources: external AER spike events and periodic leak (Tref) sweeps. It owns the time-reference timer and issues one TREF_TICK per period. Each tick launches a sweep that issues one leak operation per neuron address. Spike and leak requests are merged onto a single valid/ready channel to the core under round-robin arbitration, so neither source starves.

## Interface
Parameters:
- TREF_PERIOD, 50000: cycles between ticks; must be ≥ 2.
- N_NEURONS, 256: leak operations per sweep; must be ≥ 1.
- ADDR_W, 8: neuron address width; must satisfy 2^ADDR_W ≥ N_NEURONS.

Ports:
- CLK, in, 1: single clock; all logic is rising-edge.
- RST, in, 1: asynchronous, active-high reset.
- ENABLE, in, 1: timer run enable.
- SPIKE_VALID, in, 1: spike request.
- SPIKE_ADDR, in, ADDR_W: spike target neuron.
- SPIKE_READY, out, 1: spike accepted this cycle.
- CORE_VALID, out, 1: operation presented to the core.
- CORE_LEAK, out, 1: operation type; 1 = leak, 0 = spike.
- CORE_ADDR, out, ADDR_W: operation address.
- CORE_READY, in, 1: core accepts the operation.
- TREF_TICK, out, 1: one-cycle pulse at the end of each period.
- BUSY, out, 1: high when state = SWEEP or pending = 1.
- OVERRUN, out, 1: sticky; a tick arrived while pending was already set.

## Operation
- Timer:
  - Counter width is clog2(TREF_PERIOD).
  - Counts 0..TREF_PERIOD-1 while ENABLE = 1, then wraps to 0.
  - TREF_TICK = 1 in the cycle where count = TREF_PERIOD-1 and ENABLE = 1.
  - ENABLE = 0 clears the counter to 0 and suppresses ticks. A sweep already in progress still completes.
- Pending flag:
  - Set at the edge after TREF_TICK.
  - Cleared when the FSM enters SWEEP.
  - If a tick occurs while pending = 1: set OVERRUN and drop that tick (pending stays 1, no queue depth).
  - A tick during SWEEP with pending = 0 only sets pending.
- FSM states:
  - IDLE: if pending = 1, go to SWEEP, set leak_addr = 0, clear pending.
  - SWEEP: leak candidate = leak_addr. When a leak is loaded into the output register, leak_addr increments. The load of address N_NEURONS-1 returns the FSM to IDLE, and pending is re-evaluated the following cycle.
- Output register (one entry, holding CORE_VALID, CORE_LEAK, CORE_ADDR):
  - load_en = !CORE_VALID || CORE_READY.
  - Payload is stable while CORE_VALID && !CORE_READY.
  - If load_en = 1 and no candidate exists, CORE_VALID falls to 0.
- Arbitration, evaluated when load_en = 1:
  - Candidates are spike (SPIKE_VALID) and leak (state = SWEEP).
  - A single candidate wins.
  - If both are present, the winner is the opposite of last_grant (last_grant = 1 means the last winner was spike). last_grant updates only on contested grants; reset value 0, so spike wins the first contest.
  - SPIKE_READY = load_en && spike wins. It is combinational from SPIKE_VALID, CORE_VALID, CORE_READY and state.

## Timing
- Reset values: counter 0, pending 0, state IDLE, leak_addr 0, last_grant 0, CORE_VALID 0, CORE_LEAK 0, CORE_ADDR 0, TREF_TICK 0, BUSY 0, OVERRUN 0. Only reset clears OVERRUN.
- Tick to first leak: with tick in cycle T, pending = 1 in T+1, SWEEP in T+2, and CORE_VALID/CORE_LEAK = 1 with address 0 in T+3 (core ready, no spike).
- Spike latency: SPIKE_READY in cycle S puts the spike on CORE_VALID at S+1.
- Throughput:
  - One operation per cycle with CORE_READY held at 1.
  - An uncontested sweep takes N_NEURONS cycles.
  - A sweep under a continuous spike stream takes 2·N_NEURONS cycles, alternating leak and spike.
- Reset asserted mid-sweep: aborts immediately, with no partial sweep resumed.
- Tick in the same cycle the sweep's final leak loads: pending is set, and the next sweep starts two cycles later.

## Structure
- Package tref_sched_pkg holds:
  - OP_LEAK = 1'b1, OP_SPIKE = 1'b0.
  - A state enum {IDLE, SWEEP}.
- Sub-module tref_timer holds the counter, ENABLE handling and TREF_TICK generation.
- The FSM, arbiter and output register live in the top level.

## Test plan
Bench parameters: TREF_PERIOD = 10, N_NEURONS = 4, CORE_READY = 1 unless stated.
- Free run, no spikes: one TREF_TICK every 10 cycles; each tick is followed by leaks at addresses 0, 1, 2, 3 on consecutive cycles starting at tick+3. BUSY falls after address 3; OVERRUN stays 0.
- Spike held valid during a sweep: core sequence is S, L0, S, L1, S, L2, S, L3. SPIKE_READY toggles every cycle.
- CORE_READY = 0 for 5 cycles while L1 is presented: CORE_ADDR stays 1, SPIKE_READY = 0, and leak_addr does not advance.
- CORE_READY = 0 for 25 cycles: the second tick sets pending and the third tick sets OVERRUN. After release, exactly two sweeps run (8 leaks).
- ENABLE dropped mid-sweep: the sweep completes all 4 leaks and no further TREF_TICK occurs. ENABLE reasserted gives the first tick 10 cycles later.
- RST pulsed while L2 is on the core: all outputs return to reset values in the same cycle, and no leak is issued until the next tick.
